// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with IMM-prefix merge and valid/ready output stage.
// Optional IMMEXT_BRANCH_SHIFT_EN adds a registered out_branch_off (= out_imm << 2).
module imm_ext_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 26,
    parameter int unsigned HALF_W    = 16,
    parameter logic [5:0]  PREFIX_OP = 6'b010000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [5:0]        in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_prefixed,
    output logic              out_is_prefix
`ifdef IMMEXT_BRANCH_SHIFT_EN
    ,
    output logic [DATA_W-1:0] out_branch_off
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        PREFIXED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   upper_q, upper_d;
    logic                valid_q;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                prefixed_q, prefixed_d;
    logic                is_prefix_q, is_prefix_d;
    logic [DATA_W-1:0]   dec_imm;
    logic [DATA_W-1:0]   sext_full;
    logic [DATA_W-1:0]   sext_half;
    logic [DATA_W-1:0]   zext_half;
    logic [DATA_W-1:0]   merged;
    logic [2*HALF_W-1:0] joined;
    logic                accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    assign sext_full = DATA_W'($signed(in_imm));
    assign sext_half = DATA_W'($signed(in_imm[HALF_W-1:0]));
    assign zext_half = DATA_W'(in_imm[HALF_W-1:0]);
    assign joined    = {upper_q, in_imm[HALF_W-1:0]};
    assign merged    = DATA_W'($signed(joined));

    always_comb begin
        dec_imm = '0;
        unique case (in_opcode[5:4])
            2'b00: dec_imm = sext_full;
            2'b01: dec_imm = '0;
            2'b10: dec_imm = sext_half;
            2'b11: begin
                // Only a few class-11 ops treat the half immediate as signed
                case (in_opcode[3:0])
                    4'h2, 4'h3, 4'h7,
                    4'hD, 4'hE: dec_imm = sext_half;
                    default:    dec_imm = zext_half;
                endcase
            end
            default: dec_imm = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        upper_d     = upper_q;
        imm_d       = dec_imm;
        prefixed_d  = 1'b0;
        is_prefix_d = 1'b0;
        if (in_opcode == PREFIX_OP) begin
            imm_d       = '0;
            is_prefix_d = 1'b1;
            upper_d     = in_imm[HALF_W-1:0];
            state_d     = PREFIXED;
        end else if (state_q == PREFIXED && in_opcode[5]) begin
            // Prefix supplies the upper half; decode's sign choice is overridden
            imm_d      = merged;
            prefixed_d = 1'b1;
            state_d    = IDLE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            upper_q     <= '0;
            valid_q     <= 1'b0;
            imm_q       <= '0;
            prefixed_q  <= 1'b0;
            is_prefix_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else if (accept) begin
            valid_q     <= 1'b1;
            imm_q       <= imm_d;
            prefixed_q  <= prefixed_d;
            is_prefix_q <= is_prefix_d;
            state_q     <= state_d;
            upper_q     <= upper_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef IMMEXT_BRANCH_SHIFT_EN
    logic [DATA_W-1:0] branch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_q <= '0;
        end else if (!flush && accept) begin
            branch_q <= {imm_d[DATA_W-3:0], 2'b00};
        end
    end

    assign out_branch_off = branch_q;
`endif

    assign out_valid     = valid_q;
    assign out_imm       = imm_q;
    assign out_prefixed  = prefixed_q;
    assign out_is_prefix = is_prefix_q;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate extender for the decode stage. Generalises the combinational opcode-driven zero/sign/jump extension to any datapath width.
- Adds a registered valid/ready output stage.
- Adds an IMM-prefix state machine: a prefix instruction supplies the upper half of a full-width immediate for the next immediate-using instruction.
- Sits between instruction decode and operand select; one instruction per cycle, 1-cycle latency.

Parameters:
- DATA_W, 32, output immediate width; must be >= 2*HALF_W and >= IMM_W.
- IMM_W, 26, width of the jump-target immediate field.
- HALF_W, 16, width of the I-type immediate (low bits of in_imm).
- PREFIX_OP, 6'b010000, opcode that marks an IMM-prefix instruction.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  instruction fields valid
- in_ready  output  1  stage can accept
- in_imm  input  IMM_W  raw immediate field
- in_opcode  input  6  opcode
- out_valid  output  1  out_imm valid
- out_ready  input  1  consumer accepts
- out_imm  output  DATA_W  extended immediate
- out_prefixed  output  1  out_imm built from a prefix
- out_is_prefix  output  1  this beat is a prefix instruction

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: out_valid=0, out_imm=0, out_prefixed=0, out_is_prefix=0, state=IDLE, upper register=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; the result is registered on that edge, so latency is 1 cycle.
  - While out_valid && !out_ready, out_imm and all out_* flags are held stable.
  - out_valid clears on out_ready with no new accept.
- Extension decode, by opcode[5:4]:
  - 00: sign-extend in_imm[IMM_W-1:0].
  - 01: zero.
  - 10: sign-extend in_imm[HALF_W-1:0].
  - 11: opcode[3:0] in {2,3,7,D,E} sign-extends HALF_W; all other values zero-extend HALF_W.
- State IDLE, accepted opcode == PREFIX_OP:
  - upper <= in_imm[HALF_W-1:0]; go to PREFIXED.
  - Output beat: out_imm=0, out_is_prefix=1, out_prefixed=0.
- State IDLE, accepted opcode is anything else: normal decode; out_prefixed=0, out_is_prefix=0.
- State PREFIXED, accepted opcode == PREFIX_OP: upper is replaced; stay in PREFIXED; out_is_prefix=1.
- State PREFIXED, accepted opcode class 10 or 11:
  - out_imm = sign-extend to DATA_W of {upper, in_imm[HALF_W-1:0]}; the sign/zero choice from the decode table is ignored.
  - out_prefixed=1; go to IDLE.
- State PREFIXED, accepted class 00 or 01 (non-prefix): normal decode, out_prefixed=0, go to IDLE; the prefix is discarded.
- No accept: state and upper unchanged.
- flush:
  - out_valid <= 0 and state <= IDLE on the next edge.
  - An in_valid presented in the same cycle is dropped; in_ready is unaffected by flush.
  - flush has priority over accept and over out_ready.
- Simultaneous out_ready and accept: the new result replaces the old one in the same edge, giving full throughput.
- Reset asserted mid-prefix: upper and state are cleared immediately; the first post-reset instruction decodes normally.

Optional Feature:
- Macro: IMMEXT_BRANCH_SHIFT_EN.
- Defined:
  - Adds output port out_branch_off, DATA_W wide, registered with out_imm.
  - Value = out_imm << 2, with the upper bits truncated.
  - Held under stall exactly like out_imm; reset value 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Decode sweep, each case followed by a drain (DATA_W=32):
  - op 100011, imm 16'hFFF0 -> out_imm 32'hFFFFFFF0.
  - op 110100, imm 16'h8001 -> 32'h00008001.
  - op 110010, imm 16'h8001 -> 32'hFFFF8001.
  - op 000010, imm 26'h2000000 -> 32'hFE000000.
  - op 01xxxx (not PREFIX_OP) -> 32'h0.
- Prefix pair:
  - op 010000 imm 16'h1234 -> out_is_prefix=1, out_imm=0.
  - Then op 110100 imm 16'hABCD -> out_imm 32'h1234ABCD, out_prefixed=1.
- Prefix then jump: op 010000 imm 16'h00FF, then op 000010 imm 26'h0000010 -> out_imm 32'h00000010, out_prefixed=0. A following op 100011 imm 16'h0001 -> 32'h00000001.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_imm stable.
  - Release with in_valid=1 -> new result on the next edge, no beat lost or duplicated.
- Flush after prefix: op 010000 imm 16'h7777, then flush=1 -> out_valid=0. Next op 100011 imm 16'h8000 -> 32'hFFFF8000, out_prefixed=0.
- Async reset:
  - Assert reset mid-cycle while in PREFIXED with out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge.
  - After release, op 110101 imm 16'h0001 -> 32'h00000001.
  - With IMMEXT_BRANCH_SHIFT_EN defined, the same beat gives out_branch_off 32'h00000004.
